// File: rtl/coherence_ctrl.sv
// -----------------------------------------------------------------------------
// coherence_ctrl
//
// Bus/coherence controller shared by two cores. It owns the single RAM port
// and serialises every icache fetch, dcache write-back, snooped read miss
// (cache-to-cache or RAM fill) and S->M invalidate onto it, one transaction
// at a time.
//
// Ports
//   CLK, nRST           clock (rising edge) and asynchronous active-low reset
//   iREN, iaddr         per-core instruction fetch request / word address
//   iwait, iload        per-core fetch stall (low on completing cycle) / word
//   dREN, dWEN          per-core data read / write request
//   daddr, dstore       per-core data address / store data
//   dwait, dload        per-core data stall (low on completing cycle) / word
//   cctrans, ccwrite    per-core coherence transaction flag / wants-or-holds M
//   ccwait, ccinv       per-core snoop stall / invalidate
//   ccsnoopaddr         per-core snooped address
//   ramREN, ramWEN      RAM read / write strobe
//   ramaddr, ramstore   RAM address / write data
//   ramload, ramstate   RAM read data / status (FREE, BUSY, ACCESS, ERROR)
//
// Outputs are decoded from the registered FSM state and the live ramstate so
// a core sees its completion in the same cycle the RAM reports ACCESS. Since
// IDLE decodes to the default output set, the asynchronous reset of the state
// register drives every output to its default immediately.
// -----------------------------------------------------------------------------
module coherence_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  // instruction side
  input  logic [1:0]  iREN,
  input  logic [31:0] iaddr       [1:0],
  output logic [1:0]  iwait,
  output logic [31:0] iload       [1:0],
  // data side
  input  logic [1:0]  dREN,
  input  logic [1:0]  dWEN,
  input  logic [31:0] daddr       [1:0],
  input  logic [31:0] dstore      [1:0],
  output logic [1:0]  dwait,
  output logic [31:0] dload       [1:0],
  // coherence
  input  logic [1:0]  cctrans,
  input  logic [1:0]  ccwrite,
  output logic [1:0]  ccwait,
  output logic [1:0]  ccinv,
  output logic [31:0] ccsnoopaddr [1:0],
  // RAM
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IFETCH = 3'd1,
    DWRITE = 3'd2,
    SNOOP  = 3'd3,
    C2C    = 3'd4,
    RAMLD  = 3'd5,
    INVAL  = 3'd6
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t state_r;
  logic   gnt_r;    // core owning the current transaction
  logic   drr_r;    // data round-robin pointer: core preferred on a tie
  logic   irr_r;    // instruction round-robin pointer
  logic   wcnt_r;   // words completed in the current block transfer

  logic       oth_s;     // the core not owning the transaction
  logic       access_s;  // RAM completes a word this cycle
  logic [1:0] dreq_s;    // per-core data-side request
  logic       dgnt_s;    // data arbitration winner in IDLE
  logic       ignt_s;    // instruction arbitration winner in IDLE
  logic       abort_s;   // owner withdrew every request signal
  logic       snoop_s;   // snoop signals toward the other core are live

  assign oth_s    = ~gnt_r;
  assign access_s = (ramstate == RAM_ACCESS);
  assign dreq_s   = dREN | dWEN | cctrans;

  // Round-robin arbitration: on a tie the pointer's core wins, otherwise the
  // only requester wins.
  always_comb begin
    dgnt_s = 1'b0;
    ignt_s = 1'b0;
    if (dreq_s == 2'b11) begin
      dgnt_s = drr_r;
    end else begin
      dgnt_s = dreq_s[1];
    end
    if (iREN == 2'b11) begin
      ignt_s = irr_r;
    end else begin
      ignt_s = iREN[1];
    end
  end

  // Abort detection: the owner dropped every request signal relevant to the
  // transaction type, so the transaction is abandoned without a word.
  always_comb begin
    abort_s = 1'b0;
    case (state_r)
      IFETCH:                          abort_s = ~iREN[gnt_r];
      DWRITE, SNOOP, C2C, RAMLD, INVAL: abort_s = ~dreq_s[gnt_r];
      default:                         abort_s = 1'b0;
    endcase
  end

  // Snoop signals stay asserted on the other core from SNOOP until the block
  // transfer ends, so it cannot start its own transaction meanwhile.
  always_comb begin
    snoop_s = 1'b0;
    if ((state_r == SNOOP) || (state_r == C2C) || (state_r == RAMLD)) begin
      snoop_s = ~abort_s;
    end else begin
      snoop_s = 1'b0;
    end
  end

  // Controller FSM: arbitration, transaction sequencing and word counting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r <= IDLE;
      gnt_r   <= 1'b0;
      drr_r   <= 1'b0;
      irr_r   <= 1'b0;
      wcnt_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (|dreq_s) begin
            // Data requests take priority over instruction fetches.
            gnt_r <= dgnt_s;
            if (dgnt_s == drr_r) begin
              drr_r <= ~drr_r;
            end
            if (dWEN[dgnt_s] && !cctrans[dgnt_s]) begin
              state_r <= DWRITE;
            end else if (dREN[dgnt_s]) begin
              state_r <= SNOOP;
              wcnt_r  <= 1'b0;
            end else if (cctrans[dgnt_s] && ccwrite[dgnt_s]) begin
              state_r <= INVAL;     // S->M upgrade, no data moves
            end else if (dWEN[dgnt_s]) begin
              state_r <= DWRITE;
            end else begin
              state_r <= IDLE;      // bare cctrans: nothing to do
            end
          end else if (|iREN) begin
            gnt_r   <= ignt_s;
            state_r <= IFETCH;
            if (ignt_s == irr_r) begin
              irr_r <= ~irr_r;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        IFETCH, DWRITE: begin
          if (abort_s || access_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        SNOOP: begin
          // The snooped core answers within this single cycle.
          if (abort_s) begin
            state_r <= IDLE;
          end else if (cctrans[oth_s] && ccwrite[oth_s]) begin
            state_r <= C2C;
          end else begin
            state_r <= RAMLD;
          end
        end
        C2C, RAMLD: begin
          if (abort_s) begin
            state_r <= IDLE;
          end else if (access_s) begin
            wcnt_r <= ~wcnt_r;
            if (wcnt_r) begin
              state_r <= IDLE;      // second word of the block done
            end else begin
              state_r <= state_r;
            end
          end else begin
            state_r <= state_r;
          end
        end
        INVAL: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Output decode: defaults first, then the current state's drive. Any
  // ramstate other than ACCESS simply holds the state's outputs.
  always_comb begin
    iwait    = 2'b11;
    dwait    = 2'b11;
    ccwait   = 2'b00;
    ccinv    = 2'b00;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0000_0000;
    ramstore = 32'h0000_0000;
    for (int c = 0; c < 2; c++) begin
      iload[c]       = 32'h0000_0000;
      dload[c]       = 32'h0000_0000;
      ccsnoopaddr[c] = 32'h0000_0000;
    end

    case (state_r)
      IDLE: begin
        ramREN = 1'b0;
      end
      IFETCH: begin
        if (!abort_s) begin
          ramREN  = 1'b1;
          ramaddr = iaddr[gnt_r];
          if (access_s) begin
            iwait[gnt_r] = 1'b0;
            iload[gnt_r] = ramload;
          end else begin
            iwait[gnt_r] = 1'b1;
          end
        end else begin
          ramREN = 1'b0;
        end
      end
      DWRITE: begin
        if (!abort_s) begin
          ramWEN   = 1'b1;
          ramaddr  = daddr[gnt_r];
          ramstore = dstore[gnt_r];
          if (access_s) begin
            dwait[gnt_r] = 1'b0;
          end else begin
            dwait[gnt_r] = 1'b1;
          end
        end else begin
          ramWEN = 1'b0;
        end
      end
      SNOOP: begin
        ramREN = 1'b0;
      end
      C2C: begin
        // Owner of the modified line writes it back to RAM while the
        // requester takes the same word straight off the store bus.
        if (!abort_s) begin
          ramWEN       = 1'b1;
          ramaddr      = daddr[oth_s];
          ramstore     = dstore[oth_s];
          dload[gnt_r] = dstore[oth_s];
          if (access_s) begin
            dwait = 2'b00;
          end else begin
            dwait = 2'b11;
          end
        end else begin
          ramWEN = 1'b0;
        end
      end
      RAMLD: begin
        if (!abort_s) begin
          ramREN  = 1'b1;
          ramaddr = daddr[gnt_r];
          if (access_s) begin
            dwait[gnt_r] = 1'b0;
            dload[gnt_r] = ramload;
          end else begin
            dwait[gnt_r] = 1'b1;
          end
        end else begin
          ramREN = 1'b0;
        end
      end
      INVAL: begin
        if (!abort_s) begin
          ccwait[oth_s]      = 1'b1;
          ccinv[oth_s]       = 1'b1;
          ccsnoopaddr[oth_s] = daddr[gnt_r];
        end else begin
          ccwait[oth_s] = 1'b0;
        end
      end
      default: begin
        ramREN = 1'b0;
      end
    endcase

    if (snoop_s) begin
      ccwait[oth_s]      = 1'b1;
      ccsnoopaddr[oth_s] = daddr[gnt_r];
      ccinv[oth_s]       = ccwrite[gnt_r];
    end else begin
      ccwait[oth_s] = ccwait[oth_s];
    end
  end

endmodule

// File: doc/coherence_ctrl.md
COHERENCE_CTRL -- requirements
Module: coherence_ctrl

Interface
REQ-001 SHALL have port CLK  in  1  system clock; all state updates on rising edge.
REQ-002 SHALL have port nRST  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports iREN[1:0] in 1 and iaddr[1:0] in 32: per-core icache fetch request and word address.
REQ-004 SHALL have ports iwait[1:0] out 1 and iload[1:0] out 32: per-core fetch stall, low for exactly the completing cycle, plus fetched word.
REQ-005 SHALL have ports dREN[1:0], dWEN[1:0] in 1; daddr[1:0], dstore[1:0] in 32: per-core dcache read/write request, address, store data.
REQ-006 SHALL have ports dwait[1:0] out 1 and dload[1:0] out 32: per-core data stall, low on completing cycle, plus read data.
REQ-007 SHALL have ports cctrans[1:0], ccwrite[1:0] in 1: coherence transaction flag; ccwrite = requester wants M, or snooper holds M.
REQ-008 SHALL have ports ccwait[1:0], ccinv[1:0] out 1 and ccsnoopaddr[1:0] out 32: snoop stall, invalidate, snooped address.
REQ-009 SHALL have ports ramREN, ramWEN out 1; ramaddr, ramstore out 32; ramload in 32; ramstate in 2 (FREE=0, BUSY=1, ACCESS=2, ERROR=3).

Function
REQ-010 SHALL implement states IDLE, IFETCH, DWRITE, SNOOP, C2C, RAMLD, INVAL.
REQ-011 SHALL, in IDLE, grant data requests (dREN|dWEN|cctrans) over instruction requests.
REQ-012 SHALL arbitrate data requests via a 1-bit round-robin pointer drr, with the ungranted core first next time; drr toggles only when a data grant targets the core drr selects.
REQ-013 SHALL arbitrate iREN via separate pointer irr with the same rule.
REQ-014 SHALL go IDLE->IFETCH on instruction grant; IFETCH drives ramREN=1, ramaddr=iaddr[g]; on ramstate==ACCESS drives iwait[g]=0, iload[g]=ramload, ->IDLE.
REQ-015 SHALL go IDLE->DWRITE on dWEN without cctrans; DWRITE drives ramWEN=1, ramaddr=daddr[g], ramstore=dstore[g]; on ACCESS dwait[g]=0, ->IDLE.
REQ-016 SHALL go IDLE->SNOOP on dREN&cctrans; from SNOOP through C2C/RAMLD end, drive ccwait[o]=1, ccsnoopaddr[o]=daddr[g], ccinv[o]=ccwrite[g] (o = other core).
REQ-017 SHALL, at the end of the single SNOOP cycle, go to C2C if cctrans[o]&ccwrite[o], else RAMLD.
REQ-018 SHALL, in C2C, drive ramWEN=1, ramaddr=daddr[o], ramstore=dstore[o], dload[g]=dstore[o]; on ACCESS drive dwait[g]=0 and dwait[o]=0 together.
REQ-019 SHALL, in RAMLD, drive ramREN=1, ramaddr=daddr[g]; on ACCESS drive dwait[g]=0, dload[g]=ramload.
REQ-020 SHALL count completed words in C2C/RAMLD with a 1-bit counter cleared on SNOOP entry; second ACCESS ->IDLE.
REQ-021 SHALL go IDLE->INVAL on cctrans&ccwrite without dREN/dWEN (S->M upgrade); INVAL drives ccwait[o]=1, ccinv[o]=1, ccsnoopaddr[o]=daddr[g] for one cycle, ->IDLE.
REQ-022 SHALL treat ramstate BUSY, FREE and ERROR as not-complete and hold all outputs of the current state.
REQ-023 SHALL return to IDLE and release ccwait if the granted core drops all request signals mid-transaction, without completing a word.
REQ-024 SHALL hold dwait=1/iwait=1 for every ungranted core; a core is never granted while the other core's coherence transaction is open.
REQ-025 SHALL, when both cores request the same block simultaneously, serve drr's core fully before snooping on behalf of the other.
REQ-026 SHALL drive all non-listed outputs per cycle to defaults: waits 1, cc*/ram* controls 0, data/address 0.

Reset
REQ-027 SHALL, while nRST=0, force state IDLE, drr=0, irr=0, word counter 0, all outputs to REQ-026 defaults, immediately and regardless of clock.
REQ-028 SHALL, on reset mid-transaction, abandon it with no RAM write completing after assertion.

Verification
REQ-029 Core0 iREN, iaddr=0x40, ram ACCESS after 2 BUSY -> iwait[0] low one cycle on 3rd RAM cycle, iload[0]=ramload, back to IDLE.
REQ-030 Both dREN+cctrans, drr=0 -> core0 SNOOP->RAMLD two words 0x80/0x84, ccwait[1]=1 throughout, then core1 served, drr=1->0 pattern.
REQ-031 Core0 read miss, core1 answers cctrans=1 ccwrite=1 dstore=0xDEADBEEF -> C2C, ramstore=dload[0]=0xDEADBEEF, dwait[0]=dwait[1]=0 same cycle, twice.
REQ-032 iREN[1] and dWEN[0] same cycle -> DWRITE granted first, IFETCH next; ccinv never asserted.
REQ-033 Core1 cctrans=1 ccwrite=1 only -> single-cycle INVAL, ccinv[0]=1, ccsnoopaddr[0]=daddr[1].
REQ-034 nRST low during C2C word 1 -> all outputs default same cycle, ramWEN=0, state IDLE after release.
